// File: rtl/reduce_accum_stream.sv
// Streaming bitwise reducer: folds a valid/ready frame of WIDTH-bit words with AND/OR/XOR/NAND
// and presents one result beat per frame on an output valid/ready stream.
module reduce_accum_stream #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16,
    localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [1:0]       MODE_OR   = 2'b01;
    localparam logic [1:0]       MODE_XOR  = 2'b10;
    localparam logic [1:0]       MODE_NAND = 2'b11;
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_BEATS);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic              ovf_q, ovf_d;

    logic [WIDTH-1:0]  fold;
    logic [CNT_W-1:0]  cnt_inc;
    logic              accept;

    // NAND folds as AND; the inversion is applied only when the result is presented.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fold
        always_comb begin
            case (mode_q)
                MODE_OR:  fold[gi] = acc_q[gi] | in_data[gi];
                MODE_XOR: fold[gi] = acc_q[gi] ^ in_data[gi];
                default:  fold[gi] = acc_q[gi] & in_data[gi];
            endcase
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign accept  = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = in_data;
                    cnt_d   = CNT_W'(1);
                    mode_d  = mode;
                    ovf_d   = 1'b0;
                    state_d = in_last ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    acc_d = fold;
                    cnt_d = cnt_inc;
                    if (in_last || (cnt_inc == MAX_CNT)) begin
                        state_d = S_HOLD;
                        ovf_d   = !in_last;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
        end
    end

    // Result fields read as zero outside HOLD so stale frames never leak downstream.
    assign in_ready  = (state_q != S_HOLD);
    assign out_valid = (state_q == S_HOLD);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_valid ? ((mode_q == MODE_NAND) ? ~acc_q : acc_q) : '0;
    assign out_count = out_valid ? cnt_q : '0;
    assign out_ovf   = out_valid && ovf_q;

endmodule

// File: tb/tb_reduce_accum_stream.sv
// Directed bench for reduce_accum_stream: table-driven frames plus hand-written
// back-pressure, force-close and reset sequences.
module tb_reduce_accum_stream;

    localparam int WIDTH     = 8;
    localparam int MAX_BEATS = 16;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);

    logic             clk;
    logic             rst_n;
    logic [1:0]       mode;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
    logic             out_ready;
    logic             busy;

    int checks = 0;
    int errors = 0;

    reduce_accum_stream #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [1:0]      m;
        int              n;
        logic [3:0][7:0] d;
        logic [7:0]      exp_d;
        int              exp_c;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Drives one beat and returns after the edge on which it was accepted.
    task automatic send_beat(input logic [1:0] m, input logic [7:0] d, input logic l);
        int waited;
        waited   = 0;
        mode     = m;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_beat timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the closing beat's edge: the result must already be visible.
    task automatic finish_frame(input string name, input logic [7:0] exp_d, input int exp_c,
                                input logic exp_ovf);
        check({name, " out_valid"}, 32'(out_valid), 32'd1);
        check({name, " in_ready"}, 32'(in_ready), 32'd0);
        check({name, " busy"}, 32'(busy), 32'd1);
        check({name, " out_data"}, 32'(out_data), 32'(exp_d));
        check({name, " out_count"}, 32'(out_count), 32'(exp_c));
        check({name, " out_ovf"}, 32'(out_ovf), 32'(exp_ovf));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " released out_valid"}, 32'(out_valid), 32'd0);
        check({name, " released in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " out_valid"}, 32'(out_valid), 32'd0);
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
        check({name, " busy"}, 32'(busy), 32'd0);
        check({name, " out_data"}, 32'(out_data), 32'd0);
        check({name, " out_count"}, 32'(out_count), 32'd0);
        check({name, " out_ovf"}, 32'(out_ovf), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"and3",  2'b00, 3, {8'h00, 8'h3C, 8'hFF, 8'hF0}, 8'h30, 3};
        vecs[1] = '{"or3",   2'b01, 3, {8'h00, 8'h80, 8'h02, 8'h01}, 8'h83, 3};
        vecs[2] = '{"xor2",  2'b10, 2, {8'h00, 8'h00, 8'hFF, 8'hAA}, 8'h55, 2};
        vecs[3] = '{"nand2", 2'b11, 2, {8'h00, 8'h00, 8'h3C, 8'hF0}, 8'hCF, 2};
        vecs[4] = '{"xor1",  2'b10, 1, {8'h00, 8'h00, 8'h00, 8'h5A}, 8'h5A, 1};
        vecs[5] = '{"nand1", 2'b11, 1, {8'h00, 8'h00, 8'h00, 8'h5A}, 8'hA5, 1};
        vecs[6] = '{"xor4",  2'b10, 4, {8'h88, 8'h44, 8'h22, 8'h11}, 8'hFF, 4};

        rst_n     = 1'b0;
        mode      = 2'b00;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            for (int b = 0; b < vecs[v].n; b++) begin
                send_beat(vecs[v].m, vecs[v].d[b], (b == vecs[v].n - 1));
                if (b < vecs[v].n - 1)
                    check({vecs[v].name, " mid-frame out_valid"}, 32'(out_valid), 32'd0);
            end
            finish_frame(vecs[v].name, vecs[v].exp_d, vecs[v].exp_c, 1'b0);
        end

        // Back-pressure with a mid-frame mode change and a stalled input beat.
        send_beat(2'b00, 8'hF0, 1'b0);
        send_beat(2'b01, 8'hFF, 1'b0);
        send_beat(2'b10, 8'h3C, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h00;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("stall out_valid", 32'(out_valid), 32'd1);
            check("stall out_data", 32'(out_data), 32'h30);
            check("stall out_count", 32'(out_count), 32'd3);
            check("stall in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        finish_frame("stall", 8'h30, 3, 1'b0);

        // Force-close: 20 beats of FF, last only on beat 20.
        for (int b = 1; b <= 16; b++)
            send_beat(2'b00, 8'hFF, 1'b0);
        finish_frame("force1", 8'hFF, 16, 1'b1);
        for (int b = 17; b <= 20; b++)
            send_beat(2'b00, 8'hFF, (b == 20));
        finish_frame("force2", 8'hFF, 4, 1'b0);

        // Reset two beats into a frame.
        send_beat(2'b00, 8'hAB, 1'b0);
        send_beat(2'b00, 8'hCD, 1'b0);
        check("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after reset no output", 32'(out_valid), 32'd0);

        // Reset while a result is pending in HOLD.
        send_beat(2'b10, 8'h77, 1'b1);
        check("hold pending", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("hold reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_beat(2'b01, 8'h0F, 1'b0);
        send_beat(2'b01, 8'hF0, 1'b1);
        finish_frame("post-reset or", 8'hFF, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
